onehot_decoder_seq: RTL

Buffered, sequenced 3-to-8 one-hot decoder: the inverse of the 8-to-3 priority encoder. Accepts 3-bit codes over a valid/ready handshake into a small FIFO, then drives the corresponding one-hot line for a programmable number of cycles. Consecutive codes are separated by a one-cycle all-zero gap (break-before-make). Sits downstream of encoder/arbiter logic, turning code streams back into timed select/enable strobes.

---
 rtl/onehot_decoder_seq.sv | 60 ++++++
 1 files changed

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: FIFO-buffered 3-to-8 one-hot decoder driving each code for hold_cycles+1 cycles with a one-cycle zero gap
// Ports: code_in/code_valid/code_ready push codes into a DEPTH-entry FIFO; hold_cycles is sampled at pop;
// out is the registered one-hot strobe, out_valid = |out, busy covers FSM activity or queued codes, fifo_count is occupancy.
module onehot_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  input  logic [HOLD_W-1:0]        hold_cycles,
  output logic [7:0]               out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t            state;
  logic [2:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [HOLD_W-1:0] cnt;
  logic              push, pop;
  // ready ignores a same-cycle pop so it depends on registered state only
  assign code_ready = fifo_count < (AW+1)'(DEPTH);
  assign push = code_valid && code_ready;
  // IDLE and GAP both pop whenever something is queued
  assign pop = (state != DRIVE) && (fifo_count != '0);
  assign out_valid = |out;
  assign busy = (state != IDLE) || (fifo_count != '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      state <= IDLE;
      cnt <= '0;
      out <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= code_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (state == DRIVE) begin
        state <= (cnt == '0) ? GAP : DRIVE;
        cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
        out <= (cnt == '0) ? 8'h00 : out;
      end else begin
        state <= pop ? DRIVE : IDLE;
        cnt <= pop ? hold_cycles : cnt;
        out <= pop ? 8'd1 << mem[rd_ptr] : 8'h00;
      end
    end
  end
endmodule
